sync_word_qualifier: RTL and testbench
======================================

# sync_word_qualifier

Receive-side qualifier for multi-bit buses that arrive through the per-bit three-flop synchronizer in the `clkin` domain. Per-bit synchronization lets a changing bus be sampled with a mix of old and new bits for a cycle or two. This block accepts a new word only after it has been stable for a programmable number of consecutive cycles, then presents it once on a valid/ready handshake. It sits between the synchronizer output and the consumers of parameter and control words (voice/patch parameters, mode words).

## Interface
- `N`, 24, data width in bits.
- `STABLE_CYCLES`, 4, number of consecutive identical samples required before commit; legal range 1..255.
- `CNT_W`, 8, width of the overrun counter.

- `clkin`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sig_in`  in  N  already-synchronized bus, sampled every cycle.
- `enable`  in  1  qualification enable; when low, no new commits.
- `out_data`  out  N  last committed word.
- `out_valid`  out  1  committed word pending for the consumer.
- `out_ready`  in  1  consumer accepts `out_data` in a cycle where `out_valid` is high.
- `busy`  out  1  high while in SETTLE.
- `overrun_cnt`  out  CNT_W  saturating count of overwritten, unconsumed words.

## Operation
- Internal registers:
  - `committed` [N]: last accepted word.
  - `cand` [N]: candidate word under test.
  - `cnt` [8]: stability count.
- FSM states: IDLE, SETTLE.
- IDLE:
  - If `enable` is high and `sig_in != committed`: load `cand <= sig_in`, set `cnt <= 1`, go to SETTLE.
  - If `STABLE_CYCLES == 1`: commit directly from IDLE instead and stay in IDLE.
- SETTLE, checked in this priority order:
  - `enable` low: abort to IDLE, no commit.
  - `sig_in == committed`: the bus glitched back; return to IDLE, no commit.
  - `sig_in != cand`: restart with `cand <= sig_in`, `cnt <= 1`.
  - Else, if `cnt == STABLE_CYCLES-1`: commit and go to IDLE.
  - Else: `cnt <= cnt+1`.
- Commit (single cycle): `committed <= cand`, `out_data <= cand`, `out_valid <= 1`.
- Handshake:
  - `out_valid` stays high until a cycle with `out_ready` high.
  - `out_data` is stable while valid, except when an overrun occurs.
- Overrun: a commit while `out_valid` is high and `out_ready` is low.
  - `out_data` is replaced by the newer word.
  - `out_valid` stays high.
  - `overrun_cnt` increments, saturating at all-ones.
- Commit in the same cycle as acceptance (`out_valid` and `out_ready` high): the new word is presented, `out_valid` stays high, no overrun.
- `enable` low does not affect a pending `out_valid`.

## Timing
- Reset values:
  - `out_data = 0`, `out_valid = 0`, `busy = 0`, `overrun_cnt = 0`.
  - `committed = 0`, `cand = 0`, `cnt = 0`, state IDLE.
- Latency: new value first sampled at edge k; `out_valid` is high after edge k+STABLE_CYCLES-1, i.e. STABLE_CYCLES edges of stability.
- `busy` is registered and reflects the state.
- Reset asserted mid-SETTLE or with `out_valid` high clears everything immediately; a pending word is lost.
- A reset value of `sig_in = 0` produces no commit.
- No combinational path from `out_ready` to any output.

## Configuration
- `SYNC_QUAL_OVERRUN_CNT_EN` defined: overrun counter implemented as above.
- Not defined: no counter register; `overrun_cnt` is tied to 0. Overwrite behaviour is unchanged.

## Structure
- Package `sync_qual_pkg`:
  - FSM state typedef (IDLE, SETTLE).
  - `SQ_CNT_MAX = 255`.
  - Default constants for `N`, `STABLE_CYCLES`, `CNT_W`.
- One sub-module, `sync_qual_stab_cnt`: compare-and-count stage holding `cand`/`cnt`, with `restart` and `hit` outputs. The FSM and handshake stay in the top.
- Elaboration check: `STABLE_CYCLES` within 1..255.

## Test plan
1. Reset, then `sig_in = 0x000000` held → no `out_valid` for 50 cycles; all outputs 0.
2. `STABLE_CYCLES = 4`, `out_ready = 1`, `sig_in` steps to `0x00ABCD` at edge 10 → `out_valid` high after edge 13 for exactly one cycle, `out_data = 0x00ABCD`.
3. `sig_in` = `0x000F00` for 2 cycles, then `0x000FF0` stable → first value never committed; `0x000FF0` commits 4 edges after its first sample.
4. Glitch: `sig_in` goes `0x000001` for 2 cycles, then back to committed `0x000000` → return to IDLE, no commit, `busy` drops.
5. `out_ready = 0`, two stable words `0x000011` then `0x000022` → `out_data = 0x000022`, `overrun_cnt = 1`. Raising `out_ready` clears `out_valid` next edge. Without `SYNC_QUAL_OVERRUN_CNT_EN`, `overrun_cnt` stays 0.
6. `reset` pulsed at cnt = 2 in SETTLE, and again with `out_valid` high → outputs return to reset values asynchronously; no commit follows.

Source files
------------

// File: rtl/sync_qual_pkg.sv
// Shared types and constants for the sync word qualifier.
// Contents: FSM state type, stability-counter limit, default parameter values.
package sync_qual_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } sq_state_e;

  localparam int SQ_CNT_MAX    = 255;
  localparam int SQ_N_DEF      = 24;
  localparam int SQ_STABLE_DEF = 4;
  localparam int SQ_CNT_W_DEF  = 8;
endpackage

// File: rtl/sync_word_qualifier_if.sv
// Output handshake bundle of the sync word qualifier.
//   out_data  : committed word
//   out_valid : word pending for the consumer
//   out_ready : consumer accepts the word this cycle
// master = qualifier side, slave = consumer side.
interface sync_word_qualifier_if #(
  parameter int N = sync_qual_pkg::SQ_N_DEF
);
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/sync_qual_stab_cnt.sv
// Compare-and-count stage: holds the candidate word and its stability count.
// Ports:
//   clkin, reset : clock, async active-high reset
//   i_sig        : synchronized bus sample
//   i_load       : cand <= i_sig, cnt <= 1
//   i_inc        : cnt <= cnt + 1
//   o_cand       : current candidate
//   o_restart    : sample differs from candidate
//   o_hit        : sample matches candidate and this is the final stable cycle
module sync_qual_stab_cnt
  import sync_qual_pkg::*;
#(
  parameter int N             = SQ_N_DEF,
  parameter int STABLE_CYCLES = SQ_STABLE_DEF
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic [N-1:0] i_sig,
  input  logic         i_load,
  input  logic         i_inc,
  output logic [N-1:0] o_cand,
  output logic         o_restart,
  output logic         o_hit
);
  localparam int CW = $clog2(SQ_CNT_MAX + 1);
  localparam logic [CW-1:0] HIT_CNT = CW'(STABLE_CYCLES - 1);

  logic [N-1:0]  r_cand;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_cand <= i_sig;
      r_cnt  <= CW'(1);
    end else if (i_inc) begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_cand    = r_cand;
  assign o_restart = (i_sig != r_cand);
  // cnt counts samples already seen; the current matching sample is the last one
  assign o_hit     = !o_restart && (r_cnt == HIT_CNT);
endmodule

// File: rtl/sync_word_qualifier.sv
// Sync word qualifier: accepts a word from a per-bit-synchronized bus only
// after STABLE_CYCLES identical consecutive samples, then presents it once on
// a valid/ready handshake. Newer commits overwrite an unconsumed word.
// Ports:
//   clkin, reset  : clock, async active-high reset
//   sig_in        : synchronized bus, sampled every cycle
//   enable        : allows new commits
//   bus (master)  : out_data / out_valid / out_ready handshake
//   busy          : registered, high while in SETTLE
//   overrun_cnt   : saturating count of overwritten unconsumed words
// Build option: SYNC_QUAL_OVERRUN_CNT_EN enables the overrun counter;
// otherwise overrun_cnt is tied to zero.
module sync_word_qualifier
  import sync_qual_pkg::*;
#(
  parameter int N             = SQ_N_DEF,
  parameter int STABLE_CYCLES = SQ_STABLE_DEF,
  parameter int CNT_W         = SQ_CNT_W_DEF
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic [N-1:0]          sig_in,
  input  logic                  enable,
  sync_word_qualifier_if.master bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      overrun_cnt
);
  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > SQ_CNT_MAX) begin : g_bad_stable
      $error("STABLE_CYCLES must be within 1..255");
    end
  endgenerate

  localparam bit DIRECT = (STABLE_CYCLES == 1);

  sq_state_e    r_state;
  logic [N-1:0] r_committed;
  logic [N-1:0] r_out_data;
  logic         r_valid;
  logic         r_busy;

  logic [N-1:0] w_cand;
  logic [N-1:0] w_commit_data;
  logic         w_restart, w_hit, w_load, w_inc, w_commit, w_diff;

  assign w_diff = (sig_in != r_committed);

  sync_qual_stab_cnt #(.N(N), .STABLE_CYCLES(STABLE_CYCLES)) u_stab (
    .clkin     (clkin),
    .reset     (reset),
    .i_sig     (sig_in),
    .i_load    (w_load),
    .i_inc     (w_inc),
    .o_cand    (w_cand),
    .o_restart (w_restart),
    .o_hit     (w_hit)
  );

  always_comb begin
    w_load        = 1'b0;
    w_inc         = 1'b0;
    w_commit      = 1'b0;
    w_commit_data = w_cand;
    case (r_state)
      IDLE: if (enable && w_diff) begin
        w_load = 1'b1;
        // single-cycle stability: the first differing sample is the word
        if (DIRECT) begin
          w_commit      = 1'b1;
          w_commit_data = sig_in;
        end
      end
      SETTLE: if (enable && w_diff) begin
        if (w_restart)  w_load   = 1'b1;
        else if (w_hit) w_commit = 1'b1;
        else            w_inc    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_committed <= '0;
      r_out_data  <= '0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (enable && w_diff && !DIRECT) begin
          r_state <= SETTLE;
          r_busy  <= 1'b1;
        end
        SETTLE: if (!enable || !w_diff || w_commit) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // a commit wins over acceptance: the new word stays valid
      if (w_commit) begin
        r_committed <= w_commit_data;
        r_out_data  <= w_commit_data;
        r_valid     <= 1'b1;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SYNC_QUAL_OVERRUN_CNT_EN
  logic [CNT_W-1:0] r_ovr;
  always_ff @(posedge clkin or posedge reset) begin
    if (reset)
      r_ovr <= '0;
    else if (w_commit && r_valid && !bus.out_ready && (r_ovr != '1))
      r_ovr <= r_ovr + CNT_W'(1);
  end
  assign overrun_cnt = r_ovr;
`else
  assign overrun_cnt = '0;
`endif

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_valid;
  assign busy          = r_busy;
endmodule

// File: tb/tb_sync_word_qualifier.sv
module tb_sync_word_qualifier;
  localparam int N = 24;
`ifdef SYNC_QUAL_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] sig;
    logic         en;
    logic         rdy;
    logic         v;
    logic [N-1:0] d;
    logic         b;
    logic [7:0]   ovr;
  } vec_t;

  logic         clkin = 1'b0;
  logic         reset;
  logic [N-1:0] sig_in;
  logic         enable;
  logic         busy;
  logic [7:0]   overrun_cnt;

  sync_word_qualifier_if #(.N(N)) bus ();

  sync_word_qualifier #(.N(N), .STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .sig_in      (sig_in),
    .enable      (enable),
    .bus         (bus.master),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] s, input logic e, input logic r,
                     input logic v, input logic [N-1:0] d, input logic b, input logic [7:0] o);
    vec_t x;
    x.sig = s; x.en = e; x.rdy = r; x.v = v; x.d = d; x.b = b; x.ovr = o;
    vecs.push_back(x);
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [N-1:0] d,
                         input logic b, input logic [7:0] o);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, " data"},  32'(bus.out_data),  32'(d));
    chk({tag, " busy"},  32'(busy),          32'(b));
    chk({tag, " ovr"},   32'(overrun_cnt),   32'(OVR_EN ? o : 8'd0));
  endtask

  // drive at negedge, sample 1 time unit after the following posedge
  task automatic step(input logic [N-1:0] s, input logic e, input logic r);
    @(negedge clkin);
    sig_in = s; enable = e; bus.out_ready = r;
    @(posedge clkin);
    #1;
  endtask

  initial begin
    // glitch back to committed 0: no commit, busy drops
    add(24'h000001,1,1, 0,24'h000000,1,0);
    add(24'h000001,1,1, 0,24'h000000,1,0);
    add(24'h000000,1,1, 0,24'h000000,0,0);
    add(24'h000000,1,1, 0,24'h000000,0,0);
    // clean step: valid after the 4th stable edge, for one cycle
    add(24'h00ABCD,1,1, 0,24'h000000,1,0);
    add(24'h00ABCD,1,1, 0,24'h000000,1,0);
    add(24'h00ABCD,1,1, 0,24'h000000,1,0);
    add(24'h00ABCD,1,1, 1,24'h00ABCD,0,0);
    add(24'h00ABCD,1,1, 0,24'h00ABCD,0,0);
    // transient word is never committed; restart on the new value
    add(24'h000F00,1,1, 0,24'h00ABCD,1,0);
    add(24'h000F00,1,1, 0,24'h00ABCD,1,0);
    add(24'h000FF0,1,1, 0,24'h00ABCD,1,0);
    add(24'h000FF0,1,1, 0,24'h00ABCD,1,0);
    add(24'h000FF0,1,1, 0,24'h00ABCD,1,0);
    add(24'h000FF0,1,1, 1,24'h000FF0,0,0);
    add(24'h000FF0,1,1, 0,24'h000FF0,0,0);
    // enable low aborts settling
    add(24'h000123,1,1, 0,24'h000FF0,1,0);
    add(24'h000123,0,1, 0,24'h000FF0,0,0);
    add(24'h000123,0,1, 0,24'h000FF0,0,0);
    add(24'h000123,0,1, 0,24'h000FF0,0,0);
    // overrun: two words with ready low
    add(24'h000011,1,0, 0,24'h000FF0,1,0);
    add(24'h000011,1,0, 0,24'h000FF0,1,0);
    add(24'h000011,1,0, 0,24'h000FF0,1,0);
    add(24'h000011,1,0, 1,24'h000011,0,0);
    add(24'h000022,1,0, 1,24'h000011,1,0);
    add(24'h000022,1,0, 1,24'h000011,1,0);
    add(24'h000022,1,0, 1,24'h000011,1,0);
    add(24'h000022,1,0, 1,24'h000022,0,1);
    add(24'h000022,1,1, 0,24'h000022,0,1);
    // commit in the same cycle as acceptance: stays valid, no overrun
    add(24'h000033,1,0, 0,24'h000022,1,1);
    add(24'h000033,1,0, 0,24'h000022,1,1);
    add(24'h000033,1,0, 0,24'h000022,1,1);
    add(24'h000033,1,0, 1,24'h000033,0,1);
    add(24'h000044,1,0, 1,24'h000033,1,1);
    add(24'h000044,1,0, 1,24'h000033,1,1);
    add(24'h000044,1,0, 1,24'h000033,1,1);
    add(24'h000044,1,1, 1,24'h000044,0,1);
    add(24'h000044,1,1, 0,24'h000044,0,1);

    reset = 1'b1; sig_in = '0; enable = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk_all("in_reset", 0, 24'h0, 0, 0);
    @(negedge clkin); reset = 1'b0;

    // reset value of sig_in held: nothing ever commits
    for (int i = 0; i < 50; i++) begin
      step(24'h0, 1, 1);
      chk("idle valid", 32'(bus.out_valid), 32'd0);
      chk("idle busy",  32'(busy), 32'd0);
    end
    chk_all("idle end", 0, 24'h0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sig, vecs[i].en, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].b, vecs[i].ovr);
    end

    // reset in the middle of SETTLE (cnt = 2)
    step(24'h000055, 1, 1);
    step(24'h000055, 1, 1);
    chk("pre_rst busy", 32'(busy), 32'd1);
    @(negedge clkin); reset = 1'b1;
    #1 chk_all("rst_settle", 0, 24'h0, 0, 0);
    @(negedge clkin); reset = 1'b0; sig_in = '0;
    for (int i = 0; i < 6; i++) begin
      step(24'h0, 1, 1);
      chk_all("post_rst1", 0, 24'h0, 0, 0);
    end

    // reset with a word pending
    for (int i = 0; i < 4; i++) step(24'h000066, 1, 0);
    chk_all("pending", 1, 24'h000066, 0, 0);
    @(negedge clkin); reset = 1'b1;
    #1 chk_all("rst_valid", 0, 24'h0, 0, 0);
    @(negedge clkin); reset = 1'b0; sig_in = '0;
    for (int i = 0; i < 6; i++) begin
      step(24'h0, 1, 0);
      chk_all("post_rst2", 0, 24'h0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
